// File: rtl/frame_commit_ctrl.sv
// Write-commit scheduler: buffers register writes and drains them during blanking on commit.
// Optional FRAME_COMMIT_AUTO_EN: the falling edge of v_sync also triggers a commit in IDLE.
module frame_commit_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_req,
  input  logic              screen_inactive,
  input  logic              v_sync,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              commit_done,
  output logic              overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBlank,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   pend_q, pend_d;
  logic              overflow_q;
  logic              done_empty_q, done_empty_d;
  logic              reg_we_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_data_q;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic trigger;

  assign full = (count_q == DepthCnt);
  assign push = wr_valid && !full;

`ifdef FRAME_COMMIT_AUTO_EN
  logic vs_q;

  // Idle level of the active-low sync is high, so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= v_sync;
    end
  end

  assign trigger = commit_req || (vs_q && !v_sync && (count_q != '0));
`else
  logic unused_v_sync;
  assign unused_v_sync = v_sync;
  assign trigger = commit_req;
`endif

  // Commit sequencing; pend_q limits the drain to entries present at commit time.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pop          = 1'b0;
    done_empty_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          if (count_q != '0) begin
            state_d = StWaitBlank;
            pend_d  = count_q;
          end else begin
            done_empty_d = 1'b1;
          end
        end
      end
      StWaitBlank: begin
        if (screen_inactive) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pend_q == '0) begin
          state_d = StDone;
        end else if (screen_inactive) begin
          pop    = 1'b1;
          pend_d = pend_q - CntW'(1);
        end else begin
          state_d = StWaitBlank;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      overflow_q   <= 1'b0;
      done_empty_q <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      done_empty_q <= done_empty_d;
      reg_we_q     <= pop;
      if (wr_valid && full) begin
        overflow_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        reg_addr_q <= addr_mem[rd_ptr_q];
        reg_data_q <= data_mem[rd_ptr_q];
      end
    end
  end

  assign wr_ready    = !full;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign busy        = (state_q != StIdle);
  assign commit_done = (state_q == StDone) || done_empty_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench for frame_commit_ctrl: a queue-level model predicts register writes and
// commit_done pulses; a monitor consumes them as the DUT presents them.
module tb_frame_commit_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              commit_req = 1'b0;
  logic              screen_inactive = 1'b0;
  logic              v_sync = 1'b1;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic              busy;
  logic              commit_done;
  logic              overflow;

  always #5 clk = ~clk;

  frame_commit_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit_req     (commit_req),
    .screen_inactive(screen_inactive),
    .v_sync         (v_sync),
    .reg_we         (reg_we),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .busy           (busy),
    .commit_done    (commit_done),
    .overflow       (overflow)
  );

  typedef struct packed {
    logic              is_done;
    logic              nonempty;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  sb_t sb_q[$];       // expected DUT events in order
  wr_t queued[$];     // writes not yet claimed by a commit
  int  checks = 0;
  int  failures = 0;
  int  inflight = 0;  // committed writes not yet seen on reg_we
  int  writes_seen = 0;
  int  dones_seen = 0;
  bit  outstanding = 0;
  bit  busy_exp = 0;
  bit  clear_next = 0;
  bit  ovf_exp = 0;
  bit  vs_prev = 1;
  logic vs_drv = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Apply the spec's rules to the inputs about to be sampled at the next edge.
  task automatic model_edge();
    int   occ;
    logic trig;
    wr_t  w;
    sb_t  e;
    if (rst) begin
      queued.delete();
      sb_q.delete();
      inflight    = 0;
      outstanding = 0;
      busy_exp    = 0;
      clear_next  = 0;
      ovf_exp     = 0;
      vs_prev     = 1;
      return;
    end
    occ  = queued.size() + inflight;
    trig = commit_req;
`ifdef FRAME_COMMIT_AUTO_EN
    if (vs_prev && !v_sync && occ > 0) trig = 1'b1;
`endif
    vs_prev = v_sync;
    if (trig && !outstanding) begin
      if (occ > 0) begin
        outstanding = 1;
        busy_exp    = 1;
        while (queued.size() > 0) begin
          w = queued.pop_front();
          e.is_done = 1'b0; e.nonempty = 1'b0; e.addr = w.addr; e.data = w.data;
          sb_q.push_back(e);
          inflight++;
        end
        e.is_done = 1'b1; e.nonempty = 1'b1; e.addr = '0; e.data = '0;
        sb_q.push_back(e);
      end else begin
        e.is_done = 1'b1; e.nonempty = 1'b0; e.addr = '0; e.data = '0;
        sb_q.push_back(e);
      end
    end
    if (wr_valid) begin
      if (occ < DEPTH) begin
        w.addr = wr_addr; w.data = wr_data;
        queued.push_back(w);
      end else begin
        ovf_exp = 1;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic c, input logic si);
    wr_valid = v; wr_addr = a; wr_data = d; commit_req = c; screen_inactive = si;
    v_sync = vs_drv;
    model_edge();
    @(negedge clk);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((outstanding || sb_q.size() > 0) && n < 200) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    if (outstanding || sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", name, sb_q.size());
    end
  endtask

  task automatic drain_until(input int target, input int base);
    int n = 0;
    while ((writes_seen - base) < target && n < 50) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
  endtask

  always begin : monitor
    sb_t e;
    @(posedge clk);
    #1;
    if (clear_next) begin
      outstanding = 0;
      busy_exp    = 0;
      clear_next  = 0;
    end
    if (reg_we === 1'b1) begin
      chk("we_during_blank", int'(screen_inactive), 1);
      if (sb_q.size() == 0 || sb_q[0].is_done) begin
        checks++;
        failures++;
        $display("FAIL unexpected_reg_we: got addr=%0h data=%0h, required no write",
                 reg_addr, reg_data);
      end else begin
        e = sb_q.pop_front();
        chk("reg_addr", int'(reg_addr), int'(e.addr));
        chk("reg_data", int'(reg_data), int'(e.data));
        inflight--;
        writes_seen++;
      end
    end
    if (commit_done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0 || !sb_q[0].is_done) begin
        failures++;
        $display("FAIL unexpected_commit_done: got pulse, required %0d pending writes first",
                 inflight);
      end else begin
        e = sb_q.pop_front();
        dones_seen++;
        if (e.nonempty) clear_next = 1;
      end
    end
    chk("wr_ready", int'(wr_ready), (queued.size() + inflight < DEPTH) ? 1 : 0);
    chk("busy", int'(busy), int'(busy_exp));
    chk("overflow", int'(overflow), int'(ovf_exp));
  end

  initial begin
    int w0;
    int d0;
    logic si_r;
    rst = 1'b1;
    repeat (3) tick(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("reset_reg_we", int'(reg_we), 0);
    chk("reset_commit_done", int'(commit_done), 0);
    chk("reset_reg_addr", int'(reg_addr), 0);
    chk("reset_reg_data", int'(reg_data), 0);

    // Three writes held off while the screen is active, then drained in order.
    w0 = writes_seen; d0 = dones_seen;
    tick(1'b1, 4'd1, 14'h0A, 1'b0, 1'b0);
    tick(1'b1, 4'd2, 14'h0B, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 14'h0C, 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (6) tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t1_no_write_active", writes_seen - w0, 0);
    chk("t1_busy_waiting", int'(busy), 1);
    wait_done("t1");
    chk("t1_writes", writes_seen - w0, 3);
    chk("t1_dones", dones_seen - d0, 1);

    // Blanking ends after two pops; the rest resume at the next blank.
    w0 = writes_seen; d0 = dones_seen;
    push_rand(4);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    drain_until(2, w0);
    repeat (5) tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t2_partial_writes", writes_seen - w0, 2);
    chk("t2_busy_held", int'(busy), 1);
    wait_done("t2");
    chk("t2_writes", writes_seen - w0, 4);
    chk("t2_dones", dones_seen - d0, 1);

    // A write arriving after commit belongs to the next commit.
    w0 = writes_seen;
    push_rand(2);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    push_rand(1);
    wait_done("t3a");
    chk("t3_first_commit", writes_seen - w0, 2);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    wait_done("t3b");
    chk("t3_second_commit", writes_seen - w0, 3);

    // Fill, overflow, then commit exactly the original entries.
    w0 = writes_seen;
    push_rand(DEPTH + 1);
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t4_wr_ready_full", int'(wr_ready), 0);
    chk("t4_overflow", int'(overflow), 1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    wait_done("t4");
    chk("t4_writes", writes_seen - w0, DEPTH);
    chk("t4_overflow_sticky", int'(overflow), 1);

    // Empty commit, then reset in the middle of a drain.
    w0 = writes_seen; d0 = dones_seen;
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_empty_done", dones_seen - d0, 1);
    chk("t5_empty_writes", writes_seen - w0, 0);
    push_rand(4);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    drain_until(2, w0);
    rst = 1'b1;
    repeat (2) tick(1'b0, '0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (6) tick(1'b0, '0, '0, 1'b0, 1'b1);
    chk("t6_writes_after_rst", writes_seen - w0, 2);
    chk("t6_busy", int'(busy), 0);
    chk("t6_wr_ready", int'(wr_ready), 1);
    chk("t6_overflow", int'(overflow), 0);

`ifdef FRAME_COMMIT_AUTO_EN
    // Falling v_sync alone commits a queued write.
    w0 = writes_seen; d0 = dones_seen;
    push_rand(1);
    vs_drv = 1'b0;
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    vs_drv = 1'b1;
    wait_done("auto");
    chk("auto_writes", writes_seen - w0, 1);
    chk("auto_dones", dones_seen - d0, 1);
`endif

    // Randomized traffic; commits while busy must be ignored by the DUT as by the model.
    si_r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 15) si_r = ~si_r;
      if ($urandom_range(0, 99) < 8) vs_drv = ~vs_drv;
      tick(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, ADDR_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0, si_r);
    end
    vs_drv = 1'b1;
    wait_done("random");
    chk("final_scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_commit_ctrl.md
Name: frame_commit_ctrl

Overview:
- Schedules register writes from the SPI frontend into the rasterizer's live configuration registers, so scene updates never land mid-scanline.
- Queues address/data writes in a small FIFO. On a host commit request, waits for the VGA blanking interval and drains the queued writes one per cycle.
- Sits between the SPI frontend and the background/polygon register file. Its done pulse drives the host interrupt pin.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, register address width.
- DATA_W, 14, register data width; covers the widest packed vertex field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  1  frontend write request.
- wr_ready  out  1  FIFO can accept; equals !full.
- wr_addr  in  ADDR_W  target register address.
- wr_data  in  DATA_W  write data.
- commit_req  in  1  single-cycle pulse: apply all writes queued so far.
- screen_inactive  in  1  high during horizontal/vertical blanking.
- v_sync  in  1  active-low vertical sync, used for the commit deadline.
- reg_we  out  1  register file write strobe.
- reg_addr  out  ADDR_W  register file address.
- reg_data  out  DATA_W  register file data.
- busy  out  1  commit pending or draining.
- commit_done  out  1  one-cycle pulse when a commit completes.
- overflow  out  1  sticky; a write was attempted while full.

Behaviour:
Reset values:
- All outputs 0, except wr_ready = 1.
- FIFO empty; state IDLE; pend_cnt = 0.
- Reset mid-drain discards all queued writes; no further reg_we is issued.

FIFO:
- Push when wr_valid && wr_ready.
- Push while full is dropped and sets overflow. overflow clears only on rst.
- Push and pop in the same cycle are both legal; occupancy is unchanged.

pend_cnt:
- Count of entries belonging to the active commit, width log2(DEPTH)+1.
- Loaded in the commit_req cycle with the FIFO occupancy as of that cycle, excluding a push in the same cycle. Writes arriving later belong to the next commit.

State machine:
- IDLE:
  - commit_req with occupancy > 0 -> WAIT_BLANK; busy = 1.
  - commit_req with occupancy == 0 -> pulse commit_done the next cycle; stay IDLE.
- WAIT_BLANK:
  - screen_inactive == 1 -> DRAIN.
- DRAIN:
  - Each cycle screen_inactive == 1 and pend_cnt > 0: pop the head, drive reg_we = 1 with reg_addr/reg_data registered from the head entry, decrement pend_cnt.
  - Outputs are registered: a pop in cycle N appears on reg_* in cycle N+1.
  - screen_inactive falls with pend_cnt > 0 -> WAIT_BLANK. Remaining entries resume at the next blank, in order.
  - pend_cnt reaches 0 -> DONE.
- DONE:
  - commit_done = 1 for one cycle -> IDLE; busy = 0 in the cycle after DONE.

Commit requests:
- commit_req while busy is ignored; no queueing of commits.
- The host must wait for commit_done.

Ordering:
- reg_we writes appear in exact FIFO push order.
- Duplicate addresses are all issued; the last write wins in the register file.

Optional Feature:
FRAME_COMMIT_AUTO_EN
- Defined:
  - In IDLE, the falling edge of v_sync (start of vertical sync) acts as an implicit commit_req when the FIFO is non-empty.
  - The host never needs to pulse commit_req; explicit commit_req still works.
  - An explicit commit_req and the auto trigger in the same cycle count as one commit.
- Undefined:
  - v_sync is ignored; commits occur only on commit_req.

Test Plan:
- Queue 3 writes (addr 1/2/3, data 0x0A/0x0B/0x0C) with screen_inactive = 0, then commit_req.
  - Expect no reg_we while active.
  - After screen_inactive rises: reg_we on 3 consecutive cycles with addr 1,2,3 in order, then commit_done for exactly 1 cycle and busy = 0.
- Commit 4 entries; drop screen_inactive after the 2nd pop.
  - Expect exactly 2 writes, busy held at 1, then the remaining 2 writes at the next blank, then commit_done.
- Push 2 entries, commit_req, push 1 more during WAIT_BLANK.
  - Expect only the 2 entries written and commit_done.
  - Occupancy 1 remains; the third entry is written only after a second commit.
- Fill all 8 entries, then attempt a 9th.
  - Expect wr_ready = 0, entry dropped, overflow = 1 and sticky.
  - A commit writes exactly the original 8.
- commit_req with an empty FIFO -> commit_done next cycle, no reg_we.
  - Assert rst mid-DRAIN -> no further reg_we, wr_ready = 1, busy = 0, overflow = 0.
- With FRAME_COMMIT_AUTO_EN: queue 1 write, then v_sync falls with no commit_req.
  - Expect the write issued during blanking and a commit_done pulse.
